// File: rtl/bitblaster_pkg.sv
// Shared widths, limits and state encoding for the instruction sequencer.
package bitblaster_pkg;

  localparam int unsigned WORD_W     = 10;
  localparam int unsigned T_W        = 2;
  localparam int unsigned WDOG_LIMIT = 8;

  typedef enum logic {FETCH, EXEC} seq_state_t;

endpackage

// File: rtl/timestep_counter.sv
// Saturating timestep counter: hold beats clr, clr beats inc, stops at its maximum value.
module timestep_counter
  import bitblaster_pkg::*;
(
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           inc_i,
  input  logic           clr_i,
  input  logic           hold_i,
  output logic [T_W-1:0] t_o
);

  localparam logic [T_W-1:0] TMax = '1;

  logic [T_W-1:0] t_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      t_q <= '0;
    end else if (hold_i) begin
      t_q <= t_q;
    end else if (clr_i) begin
      t_q <= '0;
    end else if (inc_i && (t_q != TMax)) begin
      t_q <= t_q + 1'b1;
    end
  end

  assign t_o = t_q;

endmodule

// File: rtl/inst_sequencer.sv
// Fetch/execute instruction sequencer with registered IR and timestep.
// Optional stuck-instruction watchdog enabled by defining SEQ_WATCHDOG_EN.
module inst_sequencer
  import bitblaster_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [WORD_W-1:0] data_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic              ir_in_i,
  input  logic              clr_i,
  input  logic              run_i,
  output logic [WORD_W-1:0] inst_o,
  output logic [T_W-1:0]    t_o,
  output logic              done_o,
  output logic              fault_o
);

  seq_state_t        state_q;
  logic [WORD_W-1:0] inst_q;
  logic              done_q;
  logic [T_W-1:0]    t;
  logic              xfer;
  logic              exec_adv;
  logic              exec_clr;
  logic              wdog_trip;

  assign ready_o  = (state_q == FETCH) && ir_in_i && run_i;
  assign xfer     = valid_i && ready_o;
  assign exec_clr = (state_q == EXEC) && run_i && clr_i;
  assign exec_adv = (state_q == EXEC) && run_i && !clr_i;

  // A transfer moves T from 0 to 1; the watchdog clear outranks the EXEC increment.
  timestep_counter u_timestep_counter (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (xfer || exec_adv),
    .clr_i  (exec_clr || wdog_trip),
    .hold_i (!run_i),
    .t_o    (t)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= FETCH;
      inst_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= exec_clr;
      unique case (state_q)
        FETCH: begin
          if (xfer) begin
            inst_q  <= data_i;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          if (exec_clr || wdog_trip) begin
            state_q <= FETCH;
          end
        end
        default: state_q <= FETCH;
      endcase
    end
  end

`ifdef SEQ_WATCHDOG_EN
  localparam int unsigned WdogW = $clog2(WDOG_LIMIT + 1);

  logic [WdogW-1:0] wdog_q;
  logic             wdog_hit;
  logic             fault_q;

  assign wdog_hit  = exec_adv && (t == '1);
  assign wdog_trip = wdog_hit && (wdog_q == WdogW'(WDOG_LIMIT - 1));

  // Count consecutive stalled cycles at the last timestep; Run=0 freezes the count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wdog_q  <= '0;
      fault_q <= 1'b0;
    end else if (wdog_trip) begin
      wdog_q  <= '0;
      fault_q <= 1'b1;
    end else if (wdog_hit) begin
      wdog_q <= wdog_q + 1'b1;
    end else if (run_i) begin
      wdog_q <= '0;
    end
  end

  assign fault_o = fault_q;
`else
  assign wdog_trip = 1'b0;
  assign fault_o   = 1'b0;
`endif

  assign inst_o = inst_q;
  assign t_o    = t;
  assign done_o = done_q;

endmodule
